// File: rtl/sensor_proto_pkg.sv
// Request/response byte codes and FSM encoding shared by the sensor response path.
package sensor_proto_pkg;

    localparam logic [7:0] ReqHum         = 8'h00;
    localparam logic [7:0] ReqStatus      = 8'h01;
    localparam logic [7:0] ReqTemp        = 8'h02;
    localparam logic [7:0] ReqSetContTemp = 8'h03;
    localparam logic [7:0] ReqSetContHum  = 8'h04;
    localparam logic [7:0] ReqClrContTemp = 8'h05;
    localparam logic [7:0] ReqClrContHum  = 8'h06;

    localparam logic [7:0] RspHum         = 8'h0A;
    localparam logic [7:0] RspStatusOk    = 8'h08;
    localparam logic [7:0] RspFail        = 8'h1F;
    localparam logic [7:0] RspTemp        = 8'h09;
    localparam logic [7:0] RspContTemp    = 8'h0B;
    localparam logic [7:0] RspContHum     = 8'h0C;
    localparam logic [7:0] RspClrContTemp = 8'h0D;
    localparam logic [7:0] RspClrContHum  = 8'h0E;
    localparam logic [7:0] RspUnknown     = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StSendCode,
        StWaitCode,
        StSendVal,
        StWaitVal
    } state_e;

    // Requests whose reply carries a fresh sensor sample.
    function automatic logic is_measure_req(input logic [7:0] code);
        return (code == ReqHum) || (code == ReqTemp) ||
               (code == ReqSetContTemp) || (code == ReqSetContHum);
    endfunction

endpackage

// File: rtl/response_encoder.sv
// Combinational mapping from request code plus sensor state to a 2-byte response frame.
module response_encoder
    import sensor_proto_pkg::*;
(
    input  logic [7:0] i_req_code,
    input  logic       i_sensor_ok,
    input  logic       i_fail,
    input  logic [7:0] i_temp,
    input  logic [7:0] i_hum,
    output logic [7:0] o_rsp_code,
    output logic [7:0] o_rsp_data
);

    always_comb begin
        o_rsp_code = RspUnknown;
        o_rsp_data = 8'h00;
        case (i_req_code)
            ReqHum: begin
                o_rsp_code = RspHum;
                o_rsp_data = i_hum;
            end
            ReqStatus:      o_rsp_code = i_sensor_ok ? RspStatusOk : RspFail;
            ReqTemp: begin
                o_rsp_code = RspTemp;
                o_rsp_data = i_temp;
            end
            ReqSetContTemp: begin
                o_rsp_code = RspContTemp;
                o_rsp_data = i_temp;
            end
            ReqSetContHum: begin
                o_rsp_code = RspContHum;
                o_rsp_data = i_hum;
            end
            ReqClrContTemp: o_rsp_code = RspClrContTemp;
            ReqClrContHum:  o_rsp_code = RspClrContHum;
            default: ;
        endcase
        // Timeout or an unhealthy sensor replaces any measurement reply.
        if (i_fail || (is_measure_req(i_req_code) && !i_sensor_ok)) begin
            o_rsp_code = RspFail;
            o_rsp_data = 8'h00;
        end
    end

endmodule

// File: rtl/response_builder.sv
// Builds and serialises 2-byte sensor response frames towards a byte-wide UART transmitter,
// including timeout handling and continuous temperature/humidity reporting.
module response_builder #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_code,
    output logic       cmd_ready,
    input  logic       sensor_ok,
    input  logic       data_valid,
    input  logic [7:0] temp_data,
    input  logic [7:0] hum_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       busy,
    output logic       cont_temp,
    output logic       cont_hum
);
    import sensor_proto_pkg::*;

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    state_e            r_state, w_state_next;
    logic [7:0]        r_cmd, w_cmd_next;
    logic [7:0]        r_frame_code, w_frame_code_next;
    logic [7:0]        r_frame_data, w_frame_data_next;
    logic [7:0]        r_hum_hold, w_hum_hold_next;
    logic [TimerW-1:0] r_timer, w_timer_next;
    logic              r_cont_temp, w_cont_temp_next;
    logic              r_cont_hum, w_cont_hum_next;
    logic              r_pending, w_pending_next;

    logic [7:0]        w_enc_req, w_enc_temp, w_enc_hum, w_enc_code, w_enc_data;
    logic              w_enc_ok, w_enc_fail, w_load_frame;

    response_encoder u_encoder (
        .i_req_code  (w_enc_req),
        .i_sensor_ok (w_enc_ok),
        .i_fail      (w_enc_fail),
        .i_temp      (w_enc_temp),
        .i_hum       (w_enc_hum),
        .o_rsp_code  (w_enc_code),
        .o_rsp_data  (w_enc_data)
    );

    always_comb begin
        w_state_next      = r_state;
        w_cmd_next        = r_cmd;
        w_frame_code_next = r_frame_code;
        w_frame_data_next = r_frame_data;
        w_hum_hold_next   = r_hum_hold;
        w_timer_next      = r_timer;
        w_cont_temp_next  = r_cont_temp;
        w_cont_hum_next   = r_cont_hum;
        w_pending_next    = r_pending;
        w_enc_req         = cmd_code;
        w_enc_ok          = sensor_ok;
        w_enc_fail        = 1'b0;
        w_enc_temp        = temp_data;
        w_enc_hum         = hum_data;
        w_load_frame      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (cmd_valid && !r_pending) begin
                    w_cmd_next = cmd_code;
                    case (cmd_code)
                        ReqSetContTemp: w_cont_temp_next = 1'b1;
                        ReqSetContHum:  w_cont_hum_next  = 1'b1;
                        ReqClrContTemp: w_cont_temp_next = 1'b0;
                        ReqClrContHum:  w_cont_hum_next  = 1'b0;
                        default: ;
                    endcase
                    if (is_measure_req(cmd_code)) begin
                        w_state_next = StWaitData;
                        w_timer_next = '0;
                    end else begin
                        w_load_frame = 1'b1;
                        w_state_next = StSendCode;
                    end
                end else if (r_pending) begin
                    // Humidity half of a continuous sample, captured alongside the temperature.
                    w_pending_next = 1'b0;
                    w_enc_req      = ReqSetContHum;
                    w_enc_ok       = 1'b1;
                    w_enc_hum      = r_hum_hold;
                    w_load_frame   = 1'b1;
                    w_state_next   = StSendCode;
                end else if (data_valid && (r_cont_temp || r_cont_hum)) begin
                    w_enc_req       = r_cont_temp ? ReqSetContTemp : ReqSetContHum;
                    w_enc_ok        = 1'b1;
                    w_hum_hold_next = hum_data;
                    w_pending_next  = r_cont_temp && r_cont_hum;
                    w_load_frame    = 1'b1;
                    w_state_next    = StSendCode;
                end
            end
            StWaitData: begin
                w_enc_req = r_cmd;
                if (data_valid) begin
                    w_load_frame = 1'b1;
                    w_state_next = StSendCode;
                end else if (r_timer == TimerLast) begin
                    w_enc_fail   = 1'b1;
                    w_load_frame = 1'b1;
                    w_state_next = StSendCode;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            StSendCode: w_state_next = StWaitCode;
            StWaitCode: if (tx_done) w_state_next = StSendVal;
            StSendVal:  w_state_next = StWaitVal;
            StWaitVal:  if (tx_done) w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase

        if (w_load_frame) begin
            w_frame_code_next = w_enc_code;
            w_frame_data_next = w_enc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cmd        <= 8'h00;
            r_frame_code <= 8'h00;
            r_frame_data <= 8'h00;
            r_hum_hold   <= 8'h00;
            r_timer      <= '0;
            r_cont_temp  <= 1'b0;
            r_cont_hum   <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cmd        <= w_cmd_next;
            r_frame_code <= w_frame_code_next;
            r_frame_data <= w_frame_data_next;
            r_hum_hold   <= w_hum_hold_next;
            r_timer      <= w_timer_next;
            r_cont_temp  <= w_cont_temp_next;
            r_cont_hum   <= w_cont_hum_next;
            r_pending    <= w_pending_next;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (r_state)
            StSendCode, StWaitCode: tx_data = r_frame_code;
            StSendVal, StWaitVal:   tx_data = r_frame_data;
            default: ;
        endcase
    end

    assign tx_start  = (r_state == StSendCode) || (r_state == StSendVal);
    assign busy      = (r_state != StIdle);
    assign cmd_ready = (r_state == StIdle) && !r_pending;
    assign cont_temp = r_cont_temp;
    assign cont_hum  = r_cont_hum;

endmodule

// File: doc/response_builder.md
RESPONSE_BUILDER -- requirements
Module: response_builder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, max clocks to wait for sensor data_valid.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  in  1  verified command byte present; accepted when cmd_ready=1.
REQ-005 SHALL have port cmd_code  in  8  request code, sampled on acceptance.
REQ-006 SHALL have port cmd_ready  out  1  high only in IDLE.
REQ-007 SHALL have port sensor_ok  in  1  sensor health flag, sampled when frame is built.
REQ-008 SHALL have ports data_valid  in  1, temp_data  in  8, hum_data  in  8: one-cycle pulse with fresh measurement.
REQ-009 SHALL have port tx_data  out  8  byte to UART transmitter, stable from tx_start until tx_done.
REQ-010 SHALL have port tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
REQ-011 SHALL have port tx_done  in  1  one-cycle pulse, transmitter finished byte.
REQ-012 SHALL have ports busy  out  1 (not IDLE), cont_temp  out  1, cont_hum  out  1 (continuous-mode flags).

Function
REQ-013 Each response SHALL be a 2-byte frame: response code, then data byte.
REQ-014 Code map: 0x00 hum -> 0x0A,hum; 0x01 status -> (sensor_ok?0x08:0x1F),0x00; 0x02 temp -> 0x09,temp; 0x03 set cont_temp -> 0x0B,temp; 0x04 set cont_hum -> 0x0C,hum; 0x05 clear cont_temp -> 0x0D,0x00; 0x06 clear cont_hum -> 0x0E,0x00; any other -> 0xFF,0x00.
REQ-015 FSM states: IDLE, WAIT_DATA, SEND_CODE, WAIT_CODE, SEND_VAL, WAIT_VAL.
REQ-016 IDLE + cmd_valid: codes 0x00/0x02/0x03/0x04 -> WAIT_DATA; all others -> SEND_CODE.
REQ-017 WAIT_DATA: on data_valid, latch temp/hum and go SEND_CODE; timeout counter SHALL start at 0 on entry and at TIMEOUT_CYCLES-1 without data_valid frame becomes 0x1F,0x00.
REQ-018 If sensor_ok=0 when latching in WAIT_DATA, frame SHALL be 0x1F,0x00.
REQ-019 SEND_CODE: tx_start=1 one cycle with tx_data=code, -> WAIT_CODE; tx_done -> SEND_VAL; SEND_VAL: tx_start=1 with data byte, -> WAIT_VAL; tx_done -> IDLE.
REQ-020 Latency: command accepted at edge N (non-measurement) SHALL give tx_start at cycle N+1.
REQ-021 cont_temp/cont_hum SHALL update on acceptance of 0x03-0x06, before frame is sent.
REQ-022 IDLE with no cmd_valid, a data_valid while cont_temp=1 SHALL send 0x0B,temp; if also cont_hum=1, 0x0C,hum SHALL follow after temp frame (pending flag).
REQ-023 Simultaneous cmd_valid and continuous data_valid in IDLE: command wins; continuous sample dropped.
REQ-024 cmd_valid while not IDLE SHALL be ignored (cmd_ready=0); data_valid outside IDLE/WAIT_DATA ignored.
REQ-025 tx_done outside WAIT_CODE/WAIT_VAL SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, tx_start=0, tx_data=0x00, busy=0, cmd_ready=1 after release, cont_temp=0, cont_hum=0, timeout counter=0, pending flag=0.
REQ-027 Reset mid-frame SHALL abort without completing; no tx_start until a new trigger.

Structure
REQ-028 Request codes, response codes, state encoding SHALL live in shared package sensor_proto_pkg.
REQ-029 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES); one sub-module natural: response_encoder (combinational code/data mapping).

Verification
REQ-030 cmd 0x01, sensor_ok=1, tx_done 3 cycles after each start -> tx_data 0x08 then 0x00, tx_start at N+1.
REQ-031 cmd 0x02, data_valid after 10 cycles with temp=0x19 -> frame 0x09,0x19.
REQ-032 cmd 0x00, no data_valid, TIMEOUT_CYCLES=16 -> frame 0x1F,0x00 after 16 cycles.
REQ-033 cmd 0x03 then 0x04, two data_valid pulses (temp 0x1A, hum 0x30) -> 0x0B,0x1A,0x0C,0x30 per pulse; cmd 0x05 -> 0x0D,0x00 and cont_temp=0.
REQ-034 cmd 0x7F -> 0xFF,0x00; cmd_valid during busy ignored.
REQ-035 rst_n asserted in WAIT_CODE -> all outputs at reset values immediately, no second byte.
